spi_servo_slave: RTL and testbench

SPI responder (mode 0, MSB first) that receives servo steering command words from an external SPI master. It returns a status word on MISO in the same frame. SCLK, CS_N and MOSI are asynchronous to the system clock; the block oversamples them, detects edges, shifts the data and emits a one-cycle strobe with each completed command word. The strobe feeds the servo PWM stage.

---
 rtl/spi_servo_slave.sv | 204 ++++++++++++++++++++
 tb/tb_spi_servo_slave.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_servo_slave.sv
// -----------------------------------------------------------------------------
// spi_servo_slave
//
// SPI responder (mode 0, MSB first) that receives servo steering command words
// from an external master and returns a status word on MISO in the same frame.
// SCLK, CS_N and MOSI are asynchronous to clk. They are oversampled through
// synchronizer chains, edges are found against a one-flop history, and the
// frame is handled by a small state machine running entirely in the clk
// domain.
//
// Ports:
//   clk        system clock, must be at least 8x the SCLK frequency
//   rst        asynchronous active-low reset
//   sclk       SPI serial clock (async)
//   cs_n       SPI chip select, active-low (async)
//   mosi       master-out data (async)
//   miso       slave-out data
//   miso_oe    MISO pad output enable (the pad is tri-stated from this)
//   tx_data    status word, captured at frame start
//   rx_data    last correctly received command word
//   rx_valid   one-cycle strobe, rx_data updated
//   frame_err  one-cycle strobe, frame had the wrong bit count
//   busy       high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_servo_slave #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
   // Cycles spent in WAIT_IDLE before cs_n is trusted: the chain must have
   // been refilled with real samples, not the values it was reset to.
   localparam logic [2:0] WARM_CYC = 3'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2
   } state_t;

   // Synchronizers and edge history
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_hist_q;
   logic                   cs_hist_q;

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   logic sclk_rise_s;
   logic sclk_fall_s;
   logic cs_rise_s;
   logic cs_fall_s;
   logic cs_quiet_s;

   // Frame state
   state_t              state_q;
   logic [2:0]          warm_q;
   logic [DATA_W-1:0]   tx_shift_q;
   logic [DATA_W-1:0]   rx_shift_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [DATA_W-1:0]   rx_data_q;
   logic                rx_valid_q;
   logic                frame_err_q;
   logic                busy_q;
   logic                miso_q;
   logic                miso_oe_q;

   // Synchronizer chains plus one history flop for the edge-detected inputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         cs_hist_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s        = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_hist_q;
   assign sclk_fall_s = ~sclk_s & sclk_hist_q;
   assign cs_rise_s   = cs_s & ~cs_hist_q;
   assign cs_fall_s   = ~cs_s & cs_hist_q;
   // cs_n high through the whole chain and history: no falling edge in flight
   assign cs_quiet_s  = (&cs_sync_q) & cs_hist_q;

   // Frame state machine with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= WAIT_IDLE;
         warm_q      <= 3'd0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            WAIT_IDLE: begin
               if (warm_q != WARM_CYC) begin
                  warm_q <= warm_q + 3'd1;
               end else if (cs_quiet_s) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= WAIT_IDLE;
               end
            end
            IDLE: begin
               if (cs_fall_s) begin
                  tx_shift_q <= tx_data;
                  bit_cnt_q  <= '0;
                  busy_q     <= 1'b1;
                  miso_oe_q  <= 1'b1;
                  miso_q     <= tx_data[DATA_W-1];
                  state_q    <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               if (cs_rise_s) begin
                  // End of frame wins over any coincident sclk edge
                  if (bit_cnt_q == CNT_FULL) begin
                     rx_data_q  <= rx_shift_q;
                     rx_valid_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
                  busy_q    <= 1'b0;
                  miso_oe_q <= 1'b0;
                  miso_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  if (sclk_rise_s) begin
                     rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                     if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_q <= bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                     end else begin
                        bit_cnt_q <= bit_cnt_q;
                     end
                  end else begin
                     rx_shift_q <= rx_shift_q;
                  end
                  // Zeros shift in behind the status word, so MISO idles at
                  // 0 once all DATA_W bits have gone out.
                  if (sclk_fall_s) begin
                     tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                     miso_q     <= tx_shift_q[DATA_W-2];
                  end else begin
                     tx_shift_q <= tx_shift_q;
                  end
                  state_q <= SHIFT;
               end
            end
            default: begin
               busy_q    <= 1'b0;
               miso_oe_q <= 1'b0;
               miso_q    <= 1'b0;
               state_q   <= WAIT_IDLE;
            end
         endcase
      end
   end

   assign miso      = miso_q;
   assign miso_oe   = miso_oe_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spi_servo_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_servo_slave
//
// Bench for spi_servo_slave. A mode-0 SPI master task drives frames; before
// each frame the expected strobe (valid + data, or error + unchanged data) is
// queued, and a monitor on the falling clk edge pops and compares whenever the
// DUT raises rx_valid or frame_err. MISO words read by the master and the
// busy/miso_oe levels are checked directly in the stimulus flow.
// -----------------------------------------------------------------------------
module tb_spi_servo_slave;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sclk = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic          miso;
   logic          miso_oe;
   logic [DW-1:0] tx_data = '0;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          busy;

   typedef struct packed {
      logic          is_valid;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   spi_servo_slave #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .tx_data   (tx_data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic is_valid, input logic [DW-1:0] data);
      exp_t e;
      e.is_valid = is_valid;
      e.data     = data;
      exp_q.push_back(e);
   endtask

   // Mode-0 master: MOSI changes after falling SCLK, MISO captured just before
   // each rising edge. rst_at > 0 pulses reset after that many bits.
   task automatic frame(input logic [31:0] data, input int nbits, input int half,
                        input int rst_at, output logic [31:0] mword);
      mword = '0;
      cs_n  = 1'b0;
      mosi  = data[nbits-1];
      clks(half);
      for (int i = 0; i < nbits; i++) begin
         mword = {mword[30:0], miso};
         sclk  = 1'b1;
         clks(half);
         if (i == 0 && rst_at < 0) begin
            check("busy_mid_frame", {31'b0, busy}, 32'd1);
            check("oe_mid_frame", {31'b0, miso_oe}, 32'd1);
         end
         sclk = 1'b0;
         if (i + 1 < nbits) mosi = data[nbits-2-i];
         if (i + 1 == rst_at) begin
            rst = 1'b0;
            clks(3);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_oe", {31'b0, miso_oe}, 32'd0);
            check("rst_rx_data", {16'b0, rx_data}, 32'd0);
            rst = 1'b1;
         end
         clks(half);
      end
      cs_n = 1'b1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (rx_valid || frame_err) begin
         check("strobes_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: rx_valid=%0b frame_err=%0b rx_data=0x%0h, none expected",
                     rx_valid, frame_err, rx_data);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", {31'b0, rx_valid}, {31'b0, e.is_valid});
            check("strobe_rx_data", {16'b0, rx_data}, {16'b0, e.data});
         end
      end
   end

   initial begin
      logic [31:0] w;
      logic [DW-1:0] d;
      logic [DW-1:0] t;

      // Reset values
      rst = 1'b0;
      clks(3);
      check("reset_miso", {31'b0, miso}, 32'd0);
      check("reset_miso_oe", {31'b0, miso_oe}, 32'd0);
      check("reset_rx_data", {16'b0, rx_data}, 32'd0);
      check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
      check("reset_frame_err", {31'b0, frame_err}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      rst = 1'b1;
      clks(10);

      // Normal 16-bit frame
      tx_data = 16'h1234;
      push(1'b1, 16'hA55A);
      frame(32'h0000A55A, 16, 5, -1, w);
      check("miso_word_t1", {16'b0, w[15:0]}, 32'h00001234);
      clks(8);
      check("oe_after_cs", {31'b0, miso_oe}, 32'd0);
      check("busy_after_cs", {31'b0, busy}, 32'd0);
      check("miso_after_cs", {31'b0, miso}, 32'd0);
      check("rx_data_t1", {16'b0, rx_data}, 32'h0000A55A);

      // Short frame: 12 bits
      push(1'b0, 16'hA55A);
      frame(32'h00000FFF, 12, 5, -1, w);
      clks(8);
      check("rx_data_short", {16'b0, rx_data}, 32'h0000A55A);

      // Long frame: 17 bits
      push(1'b0, 16'hA55A);
      frame(32'h0001C3C3, 17, 5, -1, w);
      clks(8);
      check("rx_data_long", {16'b0, rx_data}, 32'h0000A55A);

      // Reset after 8 bits, frame completed while block waits for idle
      frame(32'h00001234, 16, 5, 8, w);
      clks(10);
      check("rx_data_post_rst", {16'b0, rx_data}, 32'd0);
      push(1'b1, 16'h0F0F);
      frame(32'h00000F0F, 16, 5, -1, w);
      clks(8);
      check("rx_data_0f0f", {16'b0, rx_data}, 32'h00000F0F);

      // Back-to-back frames with 4 clk of CS high, status changed in between
      tx_data = 16'h5AC3;
      push(1'b1, 16'h0001);
      frame(32'h00000001, 16, 5, -1, w);
      check("miso_word_b2b1", {16'b0, w[15:0]}, 32'h00005AC3);
      tx_data = 16'h3C96;
      clks(4);
      push(1'b1, 16'hFFFE);
      frame(32'h0000FFFE, 16, 5, -1, w);
      check("miso_word_b2b2", {16'b0, w[15:0]}, 32'h00003C96);
      clks(8);
      check("rx_data_b2b", {16'b0, rx_data}, 32'h0000FFFE);

      // Minimum legal SCLK phase, random data
      for (int n = 0; n < 100; n++) begin
         d = DW'($urandom);
         t = DW'($urandom);
         tx_data = t;
         push(1'b1, d);
         frame({16'b0, d}, 16, 4, -1, w);
         check("miso_word_rand", {16'b0, w[15:0]}, {16'b0, t});
         clks(4);
      end

      // Drain outstanding expectations with a bounded wait
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      clks(2);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
